shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/bit8_multiregister.sv | 31 +++
 rtl/shift_sequencer.sv | 92 +++++++++
 tb/tb_shift_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: register function codes and FSM states.
package shift_seq_pkg;

  localparam logic [1:0] F_HOLD = 2'b00;
  localparam logic [1:0] F_LOAD = 2'b01;
  localparam logic [1:0] F_LSR  = 2'b10;
  localparam logic [1:0] F_ASR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/bit8_multiregister.sv
// 8-bit register with hold / load / logical-right / arithmetic-right functions,
// updated on each rising edge while enabled.
module bit8_multiregister
  import shift_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] func,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  // A single 8-bit register (not a memory array) is cheap to reset, and an
  // aborted command must read back as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout <= 8'h00;
    end else if (en) begin
      case (func)
        F_LOAD:  dout <= din;
        F_LSR:   dout <= {1'b0, dout[7:1]};
        F_ASR:   dout <= {dout[7], dout[7:1]};
        default: dout <= dout;
      endcase
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven shift sequencer: accepts an operand and shift count, loads it,
// shifts it N times, and presents the result until the consumer takes it.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic [2:0] cmd_count,
  input  logic       cmd_arith,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       busy
);

  state_t     state, state_n;
  logic [2:0] cnt;
  logic [7:0] lat_data;
  logic [2:0] lat_count;
  logic       lat_arith;
  logic [1:0] func;
  logic       reg_en;
  logic       accept;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    func      = F_HOLD;
    reg_en    = 1'b0;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing is offered while the block is held in reset.
        cmd_ready = ~reset;
        if (cmd_valid && !reset) state_n = LOAD;
      end
      LOAD: begin
        reg_en  = 1'b1;
        func    = F_LOAD;
        state_n = (lat_count == 3'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        reg_en = 1'b1;
        func   = lat_arith ? F_ASR : F_LSR;
        if (cnt == 3'd1) state_n = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      lat_data  <= 8'h00;
      lat_count <= 3'd0;
      lat_arith <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        lat_data  <= cmd_data;
        lat_count <= cmd_count;
        lat_arith <= cmd_arith;
      end
      // SHIFT is only entered with a non-zero count, so the decrement never wraps.
      if (state == LOAD)       cnt <= lat_count;
      else if (state == SHIFT) cnt <= cnt - 3'd1;
    end
  end

  bit8_multiregister u_reg (
    .clock (clock),
    .reset (reset),
    .en    (reg_en),
    .func  (func),
    .din   (lat_data),
    .dout  (res_data)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed vector table, corner-case
// sequences, and randomized commands against an arithmetic reference model.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_arith;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] count;
    logic       arith;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs [7];

  shift_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .cmd_arith (cmd_arith),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Result of shifting d right by n places; arithmetic treats d as two's complement.
  function automatic logic [7:0] model(input logic [7:0] d, input int n, input logic a);
    int v;
    v = a ? (int'(d) - ((d > 8'd127) ? 256 : 0)) : int'(d);
    v = v >>> n;
    return v[7:0];
  endfunction

  // Issue one command, measure edges from accept (inclusive) to res_valid,
  // hold off res_ready for 'delay' cycles, then complete the handshake.
  task automatic run_cmd(input logic [7:0] d, input logic [2:0] c, input logic a,
                         input int delay, output logic [7:0] res, output int lat);
    int guard;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_count = c;
    cmd_arith = a;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      res = 8'hxx;
      lat = -1;
      return;
    end
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_count = 3'($urandom);
    cmd_arith = 1'($urandom);
    while (!res_valid && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    res = res_data;
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      check("stall_data", res_data, res);
    end
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    check("idle_after_handshake", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] d;
    logic [2:0] c;
    logic       a;
    int         lat;
    int         guard;
    int         seen;

    vecs[0] = '{8'hAA, 3'd0, 1'b1, 8'hAA, 2};
    vecs[1] = '{8'hAA, 3'd1, 1'b1, 8'hD5, 3};
    vecs[2] = '{8'hAA, 3'd1, 1'b0, 8'h55, 3};
    vecs[3] = '{8'hAA, 3'd7, 1'b1, 8'hFF, 9};
    vecs[4] = '{8'hAA, 3'd7, 1'b0, 8'h01, 9};
    vecs[5] = '{8'h3C, 3'd3, 1'b1, 8'h07, 5};
    vecs[6] = '{8'h81, 3'd2, 1'b1, 8'hE0, 4};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    cmd_count = 3'd0;
    cmd_arith = 1'b0;
    res_ready = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 8'h00);
    reset = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    // Directed vectors, first with immediate acceptance, then with a stalled consumer.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 7; i++) begin
        run_cmd(vecs[i].data, vecs[i].count, vecs[i].arith, pass * 2, res, lat);
        check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
        check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      end
    end

    // Backpressure with a second command held on cmd_valid throughout.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = 8'hAA;
    cmd_count = 3'd1;
    cmd_arith = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_data  = 8'h0F;
    cmd_count = 3'd2;
    cmd_arith = 1'b0;
    check("bp_busy", busy, 1'b1);
    check("bp_cmd_ready_busy", cmd_ready, 1'b0);
    guard = 0;
    while (!res_valid && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    check("bp_first_res", res_data, 8'hD5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_data", res_data, 8'hD5);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    check("b2b_idle_busy", busy, 1'b0);
    check("b2b_idle_ready", cmd_ready, 1'b1);
    check("b2b_idle_res_valid", res_valid, 1'b0);
    @(negedge clock);
    res_ready = 1'b0;
    @(posedge clock);
    #1;
    check("b2b_second_accept", busy, 1'b1);
    check("b2b_ready_low", cmd_ready, 1'b0);
    @(negedge clock);
    cmd_valid = 1'b0;
    guard = 0;
    while (!res_valid && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    check("b2b_second_res", res_data, 8'h03);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;

    // Reset during SHIFT after two shifts.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = 8'h80;
    cmd_count = 3'd5;
    cmd_arith = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("pre_abort_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_res_data", res_data, 8'h00);
    check("abort_res_valid", res_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_ready_after", cmd_ready, 1'b1);
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (res_valid) seen++;
    end
    check("abort_no_result", seen, 0);

    // Randomized commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      c = 3'($urandom_range(0, 7));
      a = 1'($urandom_range(0, 1));
      run_cmd(d, c, a, int'($urandom_range(0, 3)), res, lat);
      check($sformatf("rand%0d_res", i), res, model(d, int'(c), a));
      check($sformatf("rand%0d_lat", i), lat, int'(c) + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
